hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
Pipeline hazard controller for the 5-stage 19-bit-instruction core.
- Detects load-use hazards between stage 2 (register read) and stage 3, and drives `sstall` to stage 2 so the controller receives a NOP bubble.
- Sequences the front-end flush after a taken branch, jump, JSB or RET.
- Generates ALU operand forwarding selects from the stage-4 and stage-5 write-back candidates.
- Sits beside stage 2 and the pipeline registers, and owns `pcEnb` and the IF/ID register enable.

Parameters:
ADDR_W, 3, register-file address width (8 registers)
FLUSH_CYCLES, 2, number of cycles `flush` is held after a taken control transfer (1..7)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
id_r1Address  input  ADDR_W  stage-2 read address 1
id_r2Address  input  ADDR_W  stage-2 read address 2 (after R2 mux)
id_useR1  input  1  stage-2 instruction reads r1
id_useR2  input  1  stage-2 instruction reads r2
ex_dest  input  ADDR_W  stage-3 destination
ex_LDM  input  1  stage-3 instruction is a load
ex_regWrite  input  1  stage-3 writes the register file
mem_dest  input  ADDR_W  stage-4 destination
mem_regWrite  input  1  stage-4 writes the register file
wb_dest  input  ADDR_W  stage-5 destination
wb_regWrite  input  1  stage-5 writes the register file
ex_r1Address  input  ADDR_W  stage-3 operand A source address
ex_r2Address  input  ADDR_W  stage-3 operand B source address
branchTaken  input  1  stage-2 control transfer taken (pcInputSel != 0)
sstall  output  1  force NOP into the stage-2 controller
pcEnb  output  1  PC load enable
ifIdEnb  output  1  IF/ID pipeline register enable
flush  output  1  squash the IF/ID contents (insert NOP)
fwdASel  output  2  operand A select: 0 = regfile, 1 = stage 4, 2 = stage 5
fwdBSel  output  2  operand B select: same encoding as fwdASel

Behaviour:
- States: IDLE, LDSTALL, FLUSH. A 3-bit `flushCnt` is used in FLUSH.
- Reset: while `rst`=1, on the clock edge, state <= IDLE and flushCnt <= 0.
  - Outputs during and after the reset cycle: sstall=0, flush=0, pcEnb=1, ifIdEnb=1, fwd selects=0.
  - Reset mid-flush or mid-stall aborts it immediately.
- loadUse (combinational) = ex_LDM & ex_regWrite & ((id_useR1 & id_r1Address==ex_dest) | (id_useR2 & id_r2Address==ex_dest)).
- IDLE:
  - If branchTaken: flush=1 this cycle; next state FLUSH with flushCnt=FLUSH_CYCLES-1. If FLUSH_CYCLES==1, stay in IDLE.
  - Else if loadUse: sstall=1, pcEnb=0, ifIdEnb=0 this cycle; next state LDSTALL.
  - Else: pass-through, no stall or flush.
  - branchTaken has priority over loadUse.
- LDSTALL:
  - Lasts exactly one cycle. sstall=0, pcEnb=1, ifIdEnb=1, and loadUse is ignored, because stage 3 now holds the bubble.
  - branchTaken in this cycle is handled exactly as in IDLE (enter FLUSH). Otherwise return to IDLE.
- FLUSH:
  - flush=1, sstall=0, pcEnb=1.
  - loadUse and branchTaken are ignored, since the instructions are being squashed.
  - flushCnt decrements each cycle; when flushCnt==0 at the edge, return to IDLE.
  - Total flush assertion is FLUSH_CYCLES consecutive cycles.
- Control outputs are Mealy-combinational (same-cycle response); state is registered.
- Forwarding (pure combinational, independent of state):
  - fwdASel=1 if mem_regWrite & mem_dest==ex_r1Address.
  - Else fwdASel=2 if wb_regWrite & wb_dest==ex_r1Address.
  - Else fwdASel=0.
  - Stage 4 beats stage 5. fwdBSel is identical but uses ex_r2Address.
  - R0 is an ordinary register and is forwarded. Encoding 3 is never produced.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined:
  - Adds outputs `stallCount[15:0]` and `flushCount[15:0]`.
  - stallCount increments on each cycle sstall=1. flushCount increments on each IDLE→FLUSH or LDSTALL→FLUSH entry (or single-cycle flush).
  - Both counters saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and counters are absent; all other behaviour is unchanged.

Test Plan:
- Load-use hazard:
  - Stimulus: ex_LDM=1, ex_regWrite=1, ex_dest=3; id_r1Address=3, id_useR1=1.
  - Required: sstall=1, pcEnb=0, ifIdEnb=0 for exactly 1 cycle. The next cycle sstall=0 even though the inputs are held.
- No false stall:
  - Stimulus: same as the load-use case, but id_useR1=0 and id_r2Address=3 with id_useR2=0; or ex_LDM=0.
  - Required: sstall stays 0.
- Taken branch, FLUSH_CYCLES=2:
  - Stimulus: branchTaken pulse in IDLE.
  - Required: flush=1 for 2 consecutive cycles, then 0. A second branchTaken during the flush window is ignored.
- Simultaneous events:
  - Stimulus: branchTaken=1 and loadUse true in the same cycle.
  - Required: flush=1, sstall=0, state goes to FLUSH.
- Forwarding priority:
  - Stimulus: mem_dest=wb_dest=ex_r1Address=5, both regWrite=1.
  - Required: fwdASel=1. With mem_regWrite=0: fwdASel=2. With ex_r2Address=6 and no match: fwdBSel=0.
- Reset mid-flush:
  - Stimulus: assert rst during the second flush cycle.
  - Required: flush=0 on the following cycle, state IDLE. If HAZARD_PERF_CNT_EN is defined, counters read 0.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// Hazard unit bundle: stage 2-5 hazard inputs and stall/flush/forward controls.
// Counter ports exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_stall_unit_if #(
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] id_r1Address;
  logic [ADDR_W-1:0] id_r2Address;
  logic              id_useR1;
  logic              id_useR2;
  logic [ADDR_W-1:0] ex_dest;
  logic              ex_LDM;
  logic              ex_regWrite;
  logic [ADDR_W-1:0] mem_dest;
  logic              mem_regWrite;
  logic [ADDR_W-1:0] wb_dest;
  logic              wb_regWrite;
  logic [ADDR_W-1:0] ex_r1Address;
  logic [ADDR_W-1:0] ex_r2Address;
  logic              branchTaken;
  logic              sstall;
  logic              pcEnb;
  logic              ifIdEnb;
  logic              flush;
  logic [1:0]        fwdASel;
  logic [1:0]        fwdBSel;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0]       stallCount;
  logic [15:0]       flushCount;
`endif

  modport master (
    output id_r1Address, id_r2Address,
    output id_useR1, id_useR2,
    output ex_dest, ex_LDM, ex_regWrite,
    output mem_dest, mem_regWrite,
    output wb_dest, wb_regWrite,
    output ex_r1Address, ex_r2Address,
    output branchTaken,
`ifdef HAZARD_PERF_CNT_EN
    input  stallCount, flushCount,
`endif
    input  sstall, pcEnb, ifIdEnb, flush,
    input  fwdASel, fwdBSel
  );

  modport slave (
    input  id_r1Address, id_r2Address,
    input  id_useR1, id_useR2,
    input  ex_dest, ex_LDM, ex_regWrite,
    input  mem_dest, mem_regWrite,
    input  wb_dest, wb_regWrite,
    input  ex_r1Address, ex_r2Address,
    input  branchTaken,
`ifdef HAZARD_PERF_CNT_EN
    output stallCount, flushCount,
`endif
    output sstall, pcEnb, ifIdEnb, flush,
    output fwdASel, fwdBSel
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use stall, control-transfer flush and operand forwarding control.
// Optional perf counters: define HAZARD_PERF_CNT_EN.
module hazard_stall_unit #(
  parameter int ADDR_W       = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  hazard_stall_unit_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    LDSTALL,
    FLUSH
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t     state;
  state_t     nextState;
  logic [2:0] flushCnt;
  logic [2:0] nextCnt;
  logic       loadUse;
  logic       sstall;
  logic       pcEnb;
  logic       ifIdEnb;
  logic       flush;
  logic [1:0] fwdA;
  logic [1:0] fwdB;

  logic [ADDR_W-1:0] srcA;
  logic [ADDR_W-1:0] srcB;

  assign srcA = bus.ex_r1Address;
  assign srcB = bus.ex_r2Address;

  assign loadUse = bus.ex_LDM & bus.ex_regWrite &
    ((bus.id_useR1 & (bus.id_r1Address == bus.ex_dest)) |
     (bus.id_useR2 & (bus.id_r2Address == bus.ex_dest)));

  always_comb begin
    sstall    = 1'b0;
    pcEnb     = 1'b1;
    ifIdEnb   = 1'b1;
    flush     = 1'b0;
    nextState = IDLE;
    nextCnt   = flushCnt;
    if (!rst) begin
      case (state)
        FLUSH: begin
          flush = 1'b1;
          if (flushCnt <= 3'd1) begin
            nextCnt   = 3'd0;
            nextState = IDLE;
          end else begin
            nextCnt   = flushCnt - 3'd1;
            nextState = FLUSH;
          end
        end
        default: begin
          if (bus.branchTaken) begin
            flush     = 1'b1;
            nextCnt   = CNT_INIT;
            nextState = (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
          end else if (loadUse && state == IDLE) begin
            // LDSTALL skips this: stage 3 already holds the bubble
            sstall    = 1'b1;
            pcEnb     = 1'b0;
            ifIdEnb   = 1'b0;
            nextState = LDSTALL;
          end
        end
      endcase
    end
  end

  function automatic logic [1:0] fwdSel(
    input logic [ADDR_W-1:0] src,
    input logic              memWr,
    input logic [ADDR_W-1:0] memDst,
    input logic              wbWr,
    input logic [ADDR_W-1:0] wbDst
  );
    if (memWr && memDst == src)
      return 2'd1;
    else if (wbWr && wbDst == src)
      return 2'd2;
    else
      return 2'd0;
  endfunction

  always_comb begin
    fwdA = 2'd0;
    fwdB = 2'd0;
    if (!rst) begin
      fwdA = fwdSel(srcA, bus.mem_regWrite,
                    bus.mem_dest, bus.wb_regWrite,
                    bus.wb_dest);
      fwdB = fwdSel(srcB, bus.mem_regWrite,
                    bus.mem_dest, bus.wb_regWrite,
                    bus.wb_dest);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      flushCnt <= 3'd0;
    end else begin
      state    <= nextState;
      flushCnt <= nextCnt;
    end
  end

  assign bus.sstall  = sstall;
  assign bus.pcEnb   = pcEnb;
  assign bus.ifIdEnb = ifIdEnb;
  assign bus.flush   = flush;
  assign bus.fwdASel = fwdA;
  assign bus.fwdBSel = fwdB;

`ifdef HAZARD_PERF_CNT_EN
  logic        flushEntry;
  logic [15:0] stallCnt;
  logic [15:0] flushTot;

  // Only the first flush cycle of a window counts as an entry
  assign flushEntry = flush & (state != FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= 16'd0;
      flushTot <= 16'd0;
    end else begin
      if (sstall && stallCnt != 16'hFFFF)
        stallCnt <= stallCnt + 16'd1;
      if (flushEntry && flushTot != 16'hFFFF)
        flushTot <= flushTot + 16'd1;
    end
  end

  assign bus.stallCount = stallCnt;
  assign bus.flushCount = flushTot;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed cases then random traffic.
// Counter checks are active when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_stall_unit;
  localparam int AW = 3;
  localparam int FC = 2;

  typedef struct {
    bit       rst;
    bit [2:0] r1;
    bit [2:0] r2;
    bit       u1;
    bit       u2;
    bit [2:0] exDest;
    bit       ldm;
    bit       exWr;
    bit [2:0] memDest;
    bit       memWr;
    bit [2:0] wbDest;
    bit       wbWr;
    bit [2:0] exR1;
    bit [2:0] exR2;
    bit       br;
  } stim_t;

  typedef struct {
    bit       sstall;
    bit       pcEnb;
    bit       ifIdEnb;
    bit       flush;
    bit [1:0] fa;
    bit [1:0] fb;
    int       stalls;
    int       flushes;
    string    tag;
  } exp_t;

  logic clk;
  logic rst;
  int   nAssert;
  int   nFail;
  exp_t expQ[$];

  int flushLeft;
  bit bubble;
  int stalls;
  int flushes;

  hazard_stall_unit_if #(.ADDR_W(AW)) bus ();

  hazard_stall_unit #(
    .ADDR_W(AW),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act,
                     input int exp);
    nAssert++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic bit [1:0] refFwd(input stim_t s,
                                      input bit [2:0] src);
    if (s.memWr && s.memDest == src) return 2'd1;
    if (s.wbWr && s.wbDest == src) return 2'd2;
    return 2'd0;
  endfunction

  task automatic drive(input stim_t s);
    rst                  = s.rst;
    bus.id_r1Address     = s.r1;
    bus.id_r2Address     = s.r2;
    bus.id_useR1         = s.u1;
    bus.id_useR2         = s.u2;
    bus.ex_dest          = s.exDest;
    bus.ex_LDM           = s.ldm;
    bus.ex_regWrite      = s.exWr;
    bus.mem_dest         = s.memDest;
    bus.mem_regWrite     = s.memWr;
    bus.wb_dest          = s.wbDest;
    bus.wb_regWrite      = s.wbWr;
    bus.ex_r1Address     = s.exR1;
    bus.ex_r2Address     = s.exR2;
    bus.branchTaken      = s.br;
  endtask

  task automatic step(input stim_t s, input string tag);
    exp_t e;
    bit   lu;
    bit   stalledNow;
    @(posedge clk);
    #1;
    drive(s);
    e.tag     = tag;
    e.stalls  = stalls;
    e.flushes = flushes;
    e.sstall  = 0;
    e.pcEnb   = 1;
    e.ifIdEnb = 1;
    e.flush   = 0;
    e.fa      = 0;
    e.fb      = 0;
    lu = s.ldm && s.exWr &&
         ((s.u1 && s.r1 == s.exDest) ||
          (s.u2 && s.r2 == s.exDest));
    if (s.rst) begin
      flushLeft = 0;
      bubble    = 0;
      stalls    = 0;
      flushes   = 0;
    end else begin
      e.fa = refFwd(s, s.exR1);
      e.fb = refFwd(s, s.exR2);
      stalledNow = 0;
      if (flushLeft > 0) begin
        e.flush = 1;
        flushLeft--;
      end else if (s.br) begin
        e.flush   = 1;
        flushLeft = FC - 1;
        if (flushes < 65535) flushes++;
      end else if (lu && !bubble) begin
        e.sstall   = 1;
        e.pcEnb    = 0;
        e.ifIdEnb  = 0;
        stalledNow = 1;
        if (stalls < 65535) stalls++;
      end
      bubble = stalledNow;
    end
    expQ.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk({e.tag, ".sstall"}, int'(bus.sstall),
            int'(e.sstall));
        chk({e.tag, ".pcEnb"}, int'(bus.pcEnb),
            int'(e.pcEnb));
        chk({e.tag, ".ifIdEnb"}, int'(bus.ifIdEnb),
            int'(e.ifIdEnb));
        chk({e.tag, ".flush"}, int'(bus.flush),
            int'(e.flush));
        chk({e.tag, ".fwdA"}, int'(bus.fwdASel),
            int'(e.fa));
        chk({e.tag, ".fwdB"}, int'(bus.fwdBSel),
            int'(e.fb));
`ifdef HAZARD_PERF_CNT_EN
        chk({e.tag, ".stallCount"},
            int'(bus.stallCount), e.stalls);
        chk({e.tag, ".flushCount"},
            int'(bus.flushCount), e.flushes);
`endif
      end
    end
  end

  initial begin
    stim_t z;
    stim_t s;
    nAssert   = 0;
    nFail     = 0;
    flushLeft = 0;
    bubble    = 0;
    stalls    = 0;
    flushes   = 0;
    z = '{default: 0};
    s = z;
    s.rst = 1;
    drive(s);

    step(s, "reset0");
    step(s, "reset1");

    s = z;
    s.ldm = 1; s.exWr = 1; s.exDest = 3;
    s.r1 = 3; s.u1 = 1;
    step(s, "loaduse");
    step(s, "loaduse_hold");
    step(z, "idle0");

    s = z;
    s.ldm = 1; s.exWr = 1; s.exDest = 3;
    s.r1 = 3; s.u1 = 0; s.r2 = 3; s.u2 = 0;
    step(s, "nofalse_use");
    s.u1 = 1; s.ldm = 0;
    step(s, "nofalse_ldm");

    s = z;
    s.br = 1;
    step(s, "branch0");
    step(s, "branch1_ignored");
    s.br = 0;
    step(s, "branch_done");
    step(s, "branch_idle");

    s = z;
    s.br = 1; s.ldm = 1; s.exWr = 1;
    s.exDest = 2; s.r2 = 2; s.u2 = 1;
    step(s, "simul");
    s.br = 0;
    step(s, "simul_flush2");
    step(z, "idle1");

    s = z;
    s.memDest = 5; s.wbDest = 5; s.exR1 = 5;
    s.memWr = 1; s.wbWr = 1; s.exR2 = 6;
    step(s, "fwd_mem");
    s.memWr = 0;
    step(s, "fwd_wb");
    s.exR1 = 0; s.memDest = 0; s.memWr = 1;
    step(s, "fwd_r0");

    s = z;
    s.br = 1;
    step(s, "rstflush0");
    s = z;
    s.rst = 1;
    step(s, "rstflush_rst");
    step(z, "rstflush_after");

    for (int i = 0; i < 3000; i++) begin
      s.rst     = ($urandom_range(0, 49) == 0);
      s.r1      = 3'($urandom_range(0, 7));
      s.r2      = 3'($urandom_range(0, 7));
      s.u1      = ($urandom_range(0, 1) == 1);
      s.u2      = ($urandom_range(0, 1) == 1);
      s.exDest  = 3'($urandom_range(0, 7));
      s.ldm     = ($urandom_range(0, 1) == 1);
      s.exWr    = ($urandom_range(0, 3) != 0);
      s.memDest = 3'($urandom_range(0, 7));
      s.memWr   = ($urandom_range(0, 1) == 1);
      s.wbDest  = 3'($urandom_range(0, 7));
      s.wbWr    = ($urandom_range(0, 1) == 1);
      s.exR1    = 3'($urandom_range(0, 7));
      s.exR2    = 3'($urandom_range(0, 7));
      s.br      = ($urandom_range(0, 9) == 0);
      step(s, "rand");
    end

    step(z, "tail");
    for (int i = 0; i < 10 && expQ.size() > 0; i++)
      @(posedge clk);
    chk("drain", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAssert, nFail);
    $finish;
  end
endmodule
